// File: rtl/rd_req_arbiter_if.sv
// Bus bundle for rd_req_arbiter: two requester ports, the shared read request
// and response channel, and the per-requester routed responses and status.
interface rd_req_arbiter_if #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512
);
  logic                   req0_valid;
  logic [ADDR_LMT-1:0]    req0_addr;
  logic                   req0_ready;
  logic                   req1_valid;
  logic [ADDR_LMT-1:0]    req1_addr;
  logic                   req1_ready;

  logic [ADDR_LMT-1:0]    rd_req_addr;
  logic [MDATA-1:0]       rd_req_mdata;
  logic                   rd_req_en;
  logic                   rd_req_almostfull;

  logic                   rd_rsp_valid;
  logic [MDATA-1:0]       rd_rsp_mdata;
  logic [CACHE_WIDTH-1:0] rd_rsp_data;

  logic                   rsp0_valid;
  logic [CACHE_WIDTH-1:0] rsp0_data;
  logic [MDATA-2:0]       rsp0_seq;
  logic                   rsp1_valid;
  logic [CACHE_WIDTH-1:0] rsp1_data;
  logic [MDATA-2:0]       rsp1_seq;

  logic [MDATA-1:0]       out0_cnt;
  logic [MDATA-1:0]       out1_cnt;
  logic                   idle;
  logic                   tag_err;

  // master is the arbiter; slave is the requesters plus memory channel side
  modport master (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    output req0_ready, req1_ready,
    output rd_req_addr, rd_req_mdata, rd_req_en,
    input  rd_req_almostfull,
    input  rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    output rsp0_valid, rsp0_data, rsp0_seq,
    output rsp1_valid, rsp1_data, rsp1_seq,
    output out0_cnt, out1_cnt, idle, tag_err
  );

  modport slave (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    input  req0_ready, req1_ready,
    input  rd_req_addr, rd_req_mdata, rd_req_en,
    output rd_req_almostfull,
    output rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    input  rsp0_valid, rsp0_data, rsp0_seq,
    input  rsp1_valid, rsp1_data, rsp1_seq,
    input  out0_cnt, out1_cnt, idle, tag_err
  );
endinterface

// File: rtl/rd_req_arbiter.sv
// Two-requester read arbiter: round-robin issue onto one read channel with
// tagged requests, per-requester outstanding limits and response routing.
module rd_req_arbiter #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUT     = 32
) (
  input logic              clk,
  input logic              rst,
  rd_req_arbiter_if.master bus
);

  localparam logic [MDATA-1:0] MAX_CNT = MDATA'(MAX_OUT);
  localparam logic [MDATA-1:0] CNT_ONE = MDATA'(1);
  localparam logic [MDATA-2:0] SEQ_ONE = (MDATA-1)'(1);

  logic                   prio;
  logic [MDATA-2:0]       seq0;
  logic [MDATA-2:0]       seq1;
  logic [MDATA-1:0]       cnt0;
  logic [MDATA-1:0]       cnt1;

  logic [ADDR_LMT-1:0]    req_addr_q;
  logic [MDATA-1:0]       req_mdata_q;
  logic                   req_en_q;

  logic                   rsp0_valid_q;
  logic [CACHE_WIDTH-1:0] rsp0_data_q;
  logic [MDATA-2:0]       rsp0_seq_q;
  logic                   rsp1_valid_q;
  logic [CACHE_WIDTH-1:0] rsp1_data_q;
  logic [MDATA-2:0]       rsp1_seq_q;
  logic                   tag_err_q;

  logic                   elig0;
  logic                   elig1;
  logic                   grant0;
  logic                   grant1;
  logic                   rsp_hit0;
  logic                   rsp_hit1;

  // Eligibility and grant; prio breaks ties only when both can go
  always_comb begin
    elig0    = 1'b0;
    elig1    = 1'b0;
    grant0   = 1'b0;
    grant1   = 1'b0;
    rsp_hit0 = 1'b0;
    rsp_hit1 = 1'b0;
    elig0    = !rst && bus.req0_valid && !bus.rd_req_almostfull && (cnt0 < MAX_CNT);
    elig1    = !rst && bus.req1_valid && !bus.rd_req_almostfull && (cnt1 < MAX_CNT);
    grant0   = elig0 && (!elig1 || !prio);
    grant1   = elig1 && (!elig0 || prio);
    rsp_hit0 = bus.rd_rsp_valid && !bus.rd_rsp_mdata[MDATA-1];
    rsp_hit1 = bus.rd_rsp_valid &&  bus.rd_rsp_mdata[MDATA-1];
  end

  // Request issue register: address and tag hold when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      req_en_q    <= 1'b0;
      req_addr_q  <= '0;
      req_mdata_q <= '0;
      seq0        <= '0;
      seq1        <= '0;
      prio        <= 1'b0;
    end else begin
      req_en_q <= grant0 || grant1;
      if (grant0) begin
        req_addr_q  <= bus.req0_addr;
        req_mdata_q <= {1'b0, seq0};
        seq0        <= seq0 + SEQ_ONE;
        prio        <= 1'b1;
      end else if (grant1) begin
        req_addr_q  <= bus.req1_addr;
        req_mdata_q <= {1'b1, seq1};
        seq1        <= seq1 + SEQ_ONE;
        prio        <= 1'b0;
      end
    end
  end

  // Outstanding counters; a stray response at zero never underflows
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0      <= '0;
      cnt1      <= '0;
      tag_err_q <= 1'b0;
    end else begin
      unique case ({grant0, rsp_hit0})
        2'b10:   cnt0 <= cnt0 + CNT_ONE;
        2'b01:   if (cnt0 != '0) cnt0 <= cnt0 - CNT_ONE;
        default: ;
      endcase
      unique case ({grant1, rsp_hit1})
        2'b10:   cnt1 <= cnt1 + CNT_ONE;
        2'b01:   if (cnt1 != '0) cnt1 <= cnt1 - CNT_ONE;
        default: ;
      endcase
      if ((rsp_hit0 && (cnt0 == '0) && !grant0) ||
          (rsp_hit1 && (cnt1 == '0) && !grant1))
        tag_err_q <= 1'b1;
    end
  end

  // Response routing by tag MSB; data and seq hold between responses
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_seq_q   <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_seq_q   <= '0;
    end else begin
      rsp0_valid_q <= rsp_hit0;
      rsp1_valid_q <= rsp_hit1;
      if (rsp_hit0) begin
        rsp0_data_q <= bus.rd_rsp_data;
        rsp0_seq_q  <= bus.rd_rsp_mdata[MDATA-2:0];
      end
      if (rsp_hit1) begin
        rsp1_data_q <= bus.rd_rsp_data;
        rsp1_seq_q  <= bus.rd_rsp_mdata[MDATA-2:0];
      end
    end
  end

  assign bus.req0_ready   = grant0;
  assign bus.req1_ready   = grant1;
  assign bus.rd_req_en    = req_en_q;
  assign bus.rd_req_addr  = req_addr_q;
  assign bus.rd_req_mdata = req_mdata_q;
  assign bus.rsp0_valid   = rsp0_valid_q;
  assign bus.rsp0_data    = rsp0_data_q;
  assign bus.rsp0_seq     = rsp0_seq_q;
  assign bus.rsp1_valid   = rsp1_valid_q;
  assign bus.rsp1_data    = rsp1_data_q;
  assign bus.rsp1_seq     = rsp1_seq_q;
  assign bus.out0_cnt     = cnt0;
  assign bus.out1_cnt     = cnt1;
  assign bus.tag_err      = tag_err_q;
  assign bus.idle         = (cnt0 == '0) && (cnt1 == '0) && !req_en_q;

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Directed bench for rd_req_arbiter with MAX_OUT=4 so the outstanding limit
// is reachable; expected values are hand-computed per step.
module tb_rd_req_arbiter;

  localparam int ADDR_LMT    = 20;
  localparam int MDATA       = 14;
  localparam int CACHE_WIDTH = 512;
  localparam int MAX_OUT     = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rd_req_arbiter_if #(.ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CACHE_WIDTH)) bus ();

  rd_req_arbiter #(
    .ADDR_LMT(ADDR_LMT), .MDATA(MDATA), .CACHE_WIDTH(CACHE_WIDTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkData(input string tag, input logic [CACHE_WIDTH-1:0] observed, input logic [CACHE_WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [ADDR_LMT-1:0] a0,
                               input logic v1, input logic [ADDR_LMT-1:0] a1,
                               input logic af, input logic rv,
                               input logic [MDATA-1:0] rm, input logic [CACHE_WIDTH-1:0] rd);
    bus.req0_valid        = v0;
    bus.req0_addr         = a0;
    bus.req1_valid        = v1;
    bus.req1_addr         = a1;
    bus.rd_req_almostfull = af;
    bus.rd_rsp_valid      = rv;
    bus.rd_rsp_mdata      = rm;
    bus.rd_rsp_data       = rd;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b1, 20'h00010, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput("rst_ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("rst_en", 32'(bus.rd_req_en), 32'd0);
    checkOutput("rst_idle", 32'(bus.idle), 32'd1);
    checkOutput("rst_cnt0", 32'(bus.out0_cnt), 32'd0);
    checkOutput("rst_tag_err", 32'(bus.tag_err), 32'd0);

    // Single requester, three back-to-back issues
    rst = 1'b0;
    #1;
    checkOutput("t1_ready0", 32'(bus.req0_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t1_en", 32'(bus.rd_req_en), 32'd1);
      checkOutput("t1_addr", 32'(bus.rd_req_addr), 32'h00010);
      checkOutput("t1_mdata", 32'(bus.rd_req_mdata), 32'(i));
    end
    checkOutput("t1_cnt0", 32'(bus.out0_cnt), 32'd3);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("t1_en_off", 32'(bus.rd_req_en), 32'd0);
    checkOutput("t1_mdata_hold", 32'(bus.rd_req_mdata), 32'h0002);
    checkOutput("t1_idle_busy", 32'(bus.idle), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, MDATA'(i), CACHE_WIDTH'(32'h1000 + i));
      tick();
      checkOutput("t1_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      checkOutput("t1_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
      checkOutput("t1_rsp0_seq", 32'(bus.rsp0_seq), 32'(i));
      checkData("t1_rsp0_data", bus.rsp0_data, CACHE_WIDTH'(32'h1000 + i));
      checkOutput("t1_cnt0_dec", 32'(bus.out0_cnt), 32'(2 - i));
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("t1_idle", 32'(bus.idle), 32'd1);
    checkOutput("t1_tag_err", 32'(bus.tag_err), 32'd0);

    // Both requesters: alternation starting with requester 0
    doReset();
    applyStimulus(1'b1, 20'h00100, 1'b1, 20'h00200, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("t2_ready0", 32'(bus.req0_ready), 32'd1);
    checkOutput("t2_ready1", 32'(bus.req1_ready), 32'd0);
    tick();
    checkOutput("t2_addr_a", 32'(bus.rd_req_addr), 32'h00100);
    checkOutput("t2_mdata_a", 32'(bus.rd_req_mdata), 32'h0000);
    tick();
    checkOutput("t2_addr_b", 32'(bus.rd_req_addr), 32'h00200);
    checkOutput("t2_mdata_b", 32'(bus.rd_req_mdata), 32'h2000);
    tick();
    checkOutput("t2_addr_c", 32'(bus.rd_req_addr), 32'h00100);
    checkOutput("t2_mdata_c", 32'(bus.rd_req_mdata), 32'h0001);
    tick();
    checkOutput("t2_addr_d", 32'(bus.rd_req_addr), 32'h00200);
    checkOutput("t2_mdata_d", 32'(bus.rd_req_mdata), 32'h2001);
    checkOutput("t2_cnt0", 32'(bus.out0_cnt), 32'd2);
    checkOutput("t2_cnt1", 32'(bus.out1_cnt), 32'd2);

    // Outstanding limit blocks only requester 0
    doReset();
    applyStimulus(1'b1, 20'h00040, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("t3_en", 32'(bus.rd_req_en), 32'd1);
      checkOutput("t3_mdata", 32'(bus.rd_req_mdata), 32'(i));
    end
    checkOutput("t3_cnt0_max", 32'(bus.out0_cnt), 32'd4);
    checkOutput("t3_ready0_blk", 32'(bus.req0_ready), 32'd0);
    tick();
    checkOutput("t3_en_blk", 32'(bus.rd_req_en), 32'd0);
    applyStimulus(1'b1, 20'h00040, 1'b1, 20'h00080, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("t3_ready1", 32'(bus.req1_ready), 32'd1);
    tick();
    checkOutput("t3_en1", 32'(bus.rd_req_en), 32'd1);
    checkOutput("t3_addr1", 32'(bus.rd_req_addr), 32'h00080);
    checkOutput("t3_mdata1", 32'(bus.rd_req_mdata), 32'h2000);
    applyStimulus(1'b1, 20'h00040, 1'b0, '0, 1'b0, 1'b1, 14'h0000, CACHE_WIDTH'(32'h55));
    #1;
    checkOutput("t3_ready0_still", 32'(bus.req0_ready), 32'd0);
    tick();
    checkOutput("t3_cnt0_dec", 32'(bus.out0_cnt), 32'd3);
    checkOutput("t3_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    applyStimulus(1'b1, 20'h00040, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    #1;
    checkOutput("t3_ready0_again", 32'(bus.req0_ready), 32'd1);
    tick();
    checkOutput("t3_en_again", 32'(bus.rd_req_en), 32'd1);
    checkOutput("t3_mdata_again", 32'(bus.rd_req_mdata), 32'h0004);
    checkOutput("t3_cnt0_again", 32'(bus.out0_cnt), 32'd4);

    // Almostfull stalls issue; responses still flow and decrement
    applyStimulus(1'b1, 20'h00040, 1'b1, 20'h00080, 1'b1, 1'b0, '0, '0);
    #1;
    checkOutput("t4_ready0", 32'(bus.req0_ready), 32'd0);
    checkOutput("t4_ready1", 32'(bus.req1_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t4_en", 32'(bus.rd_req_en), 32'd0);
    end
    applyStimulus(1'b1, 20'h00040, 1'b1, 20'h00080, 1'b1, 1'b1, 14'h2000, {64{8'hAB}});
    tick();
    checkOutput("t4_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    checkOutput("t4_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    checkData("t4_rsp1_data", bus.rsp1_data, {64{8'hAB}});
    checkOutput("t4_rsp1_seq", 32'(bus.rsp1_seq), 32'd0);
    checkOutput("t4_cnt1", 32'(bus.out1_cnt), 32'd0);
    checkOutput("t4_cnt0", 32'(bus.out0_cnt), 32'd4);

    // Same-cycle grant and response at zero; then a stray response
    doReset();
    applyStimulus(1'b1, 20'h00300, 1'b0, '0, 1'b0, 1'b1, 14'h0000, CACHE_WIDTH'(32'h11));
    tick();
    checkOutput("t5_en", 32'(bus.rd_req_en), 32'd1);
    checkOutput("t5_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    checkOutput("t5_cnt0_same", 32'(bus.out0_cnt), 32'd0);
    checkOutput("t5_tag_err_clr", 32'(bus.tag_err), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 14'h0005, CACHE_WIDTH'(32'h22));
    tick();
    checkOutput("t5_stray_valid", 32'(bus.rsp0_valid), 32'd1);
    checkOutput("t5_stray_seq", 32'(bus.rsp0_seq), 32'd5);
    checkData("t5_stray_data", bus.rsp0_data, CACHE_WIDTH'(32'h22));
    checkOutput("t5_stray_cnt0", 32'(bus.out0_cnt), 32'd0);
    checkOutput("t5_tag_err", 32'(bus.tag_err), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checkOutput("t5_tag_err_sticky", 32'(bus.tag_err), 32'd1);
    checkOutput("t5_rsp0_off", 32'(bus.rsp0_valid), 32'd0);

    // Reset in the middle of a burst, with a response presented during reset
    applyStimulus(1'b1, 20'h00100, 1'b1, 20'h00200, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 20'h00100, 1'b1, 20'h00200, 1'b0, 1'b1, 14'h2000, {64{8'hFF}});
    #1;
    checkOutput("t6_ready0_rst", 32'(bus.req0_ready), 32'd0);
    checkOutput("t6_ready1_rst", 32'(bus.req1_ready), 32'd0);
    tick();
    checkOutput("t6_en", 32'(bus.rd_req_en), 32'd0);
    checkOutput("t6_addr", 32'(bus.rd_req_addr), 32'd0);
    checkOutput("t6_mdata", 32'(bus.rd_req_mdata), 32'd0);
    checkOutput("t6_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    checkOutput("t6_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    checkData("t6_rsp0_data", bus.rsp0_data, '0);
    checkData("t6_rsp1_data", bus.rsp1_data, '0);
    checkOutput("t6_rsp0_seq", 32'(bus.rsp0_seq), 32'd0);
    checkOutput("t6_cnt0", 32'(bus.out0_cnt), 32'd0);
    checkOutput("t6_cnt1", 32'(bus.out1_cnt), 32'd0);
    checkOutput("t6_tag_err", 32'(bus.tag_err), 32'd0);
    checkOutput("t6_idle", 32'(bus.idle), 32'd1);
    rst = 1'b0;
    applyStimulus(1'b1, 20'h00100, 1'b1, 20'h00200, 1'b0, 1'b0, '0, '0);
    tick();
    checkOutput("t6_post_addr", 32'(bus.rd_req_addr), 32'h00100);
    checkOutput("t6_post_mdata", 32'(bus.rd_req_mdata), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
